// File: rtl/i2s_pkg.sv
// Constants shared by the I2S transmitter and receiver.
package i2s_pkg;

    localparam int I2S_WORD_SIZE_DEF = 24;

    typedef enum logic {
        I2S_CH_LEFT  = 1'b0,
        I2S_CH_RIGHT = 1'b1
    } i2s_ch_e;

    // Bit-index width able to hold 0..ws, where ws itself encodes "idle".
    function automatic int i2s_idx_w(input int ws);
        return $clog2(ws + 1);
    endfunction

endpackage

// File: rtl/i2s_ws_detect.sv
// Word-select transition detector on falling bck; shared with the I2S receiver.
module i2s_ws_detect
    import i2s_pkg::*;
(
    input  logic    bck,
    input  logic    rst,
    input  logic    lrck_i,
    output logic    ws_edge_o,
    output i2s_ch_e ch_o
);

    // lrck as seen on the previous falling edge
    logic lrck_q;

    always_ff @(negedge bck or posedge rst) begin
        if (rst) lrck_q <= 1'b0;
        else     lrck_q <= lrck_i;
    end

    assign ws_edge_o = lrck_i ^ lrck_q;
    assign ch_o      = i2s_ch_e'(lrck_i);

endmodule

// File: rtl/i2s_tx.sv
// Slave-mode I2S transmitter with a one-pair input buffer and per-frame L/R latch.
// Build option I2S_TX_HOLD_LAST_EN: repeat the last pair on underrun instead of muting.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int WORD_SIZE = I2S_WORD_SIZE_DEF
) (
    input  logic                 bck,
    input  logic                 rst,
    input  logic                 lrck,
    input  logic [WORD_SIZE-1:0] l_din,
    input  logic [WORD_SIZE-1:0] r_din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 dout,
    output logic                 underrun
);

    localparam int               IDX_W     = i2s_idx_w(WORD_SIZE);
    localparam logic [IDX_W-1:0] IDX_IDLE  = IDX_W'(WORD_SIZE);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(WORD_SIZE - 2);

    logic    ws_edge;
    i2s_ch_e ch;
    logic    left_start;
    logic    hs;

    logic [WORD_SIZE-1:0] l_buf_q, l_buf_d, r_buf_q, r_buf_d;
    logic [WORD_SIZE-1:0] l_frame_q, l_frame_d, r_frame_q, r_frame_d;
    logic [WORD_SIZE-1:0] cur_word;
    logic                 full_q, full_d;
    logic                 ready_q, ready_d;
    logic                 underrun_q, underrun_d;
    logic                 dout_q, dout_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;

    i2s_ws_detect u_ws (
        .bck       (bck),
        .rst       (rst),
        .lrck_i    (lrck),
        .ws_edge_o (ws_edge),
        .ch_o      (ch)
    );

    assign left_start = ws_edge && (ch == I2S_CH_LEFT);
    assign hs         = din_valid && ready_q;

    // Buffer and frame latch; a same-edge handshake still lands in the buffer only.
    always_comb begin
        l_buf_d    = l_buf_q;
        r_buf_d    = r_buf_q;
        full_d     = full_q;
        l_frame_d  = l_frame_q;
        r_frame_d  = r_frame_q;
        underrun_d = 1'b0;
        if (left_start) begin
            if (full_q) begin
                l_frame_d = l_buf_q;
                r_frame_d = r_buf_q;
                full_d    = 1'b0;
            end else begin
`ifdef I2S_TX_HOLD_LAST_EN
                l_frame_d = l_frame_q;
                r_frame_d = r_frame_q;
`else
                l_frame_d = '0;
                r_frame_d = '0;
`endif
                underrun_d = 1'b1;
            end
        end
        if (hs) begin
            l_buf_d = l_din;
            r_buf_d = r_din;
            full_d  = 1'b1;
        end
        ready_d = !full_d;
    end

    // Serialiser: a word-select edge always restarts at the MSB, truncating any word in flight.
    always_comb begin
        cur_word  = (ch == I2S_CH_LEFT) ? l_frame_d : r_frame_d;
        dout_d    = 1'b0;
        bit_idx_d = bit_idx_q;
        if (ws_edge) begin
            dout_d    = cur_word[WORD_SIZE-1];
            bit_idx_d = IDX_FIRST;
        end else if (bit_idx_q < IDX_IDLE) begin
            dout_d    = cur_word[bit_idx_q];
            bit_idx_d = (bit_idx_q == '0) ? IDX_IDLE : bit_idx_q - IDX_W'(1);
        end
    end

    always_ff @(negedge bck or posedge rst) begin
        if (rst) begin
            l_buf_q    <= '0;
            r_buf_q    <= '0;
            full_q     <= 1'b0;
            ready_q    <= 1'b1;
            l_frame_q  <= '0;
            r_frame_q  <= '0;
            underrun_q <= 1'b0;
            dout_q     <= 1'b0;
            bit_idx_q  <= IDX_IDLE;
        end else begin
            l_buf_q    <= l_buf_d;
            r_buf_q    <= r_buf_d;
            full_q     <= full_d;
            ready_q    <= ready_d;
            l_frame_q  <= l_frame_d;
            r_frame_q  <= r_frame_d;
            underrun_q <= underrun_d;
            dout_q     <= dout_d;
            bit_idx_q  <= bit_idx_d;
        end
    end

    assign din_ready = ready_q;
    assign dout      = dout_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Randomised scoreboard bench for i2s_tx: a slot-position model predicts dout/din_ready/underrun.
module tb_i2s_tx;

    localparam int WS = 24;

    logic          bck       = 1'b0;
    logic          rst       = 1'b0;
    logic          lrck      = 1'b0;
    logic          din_valid = 1'b0;
    logic [WS-1:0] l_din     = '0;
    logic [WS-1:0] r_din     = '0;
    logic          din_ready, dout, underrun;

    int checks = 0;
    int errors = 0;

    always #5 bck = ~bck;

    i2s_tx #(.WORD_SIZE(WS)) dut (
        .bck       (bck),
        .rst       (rst),
        .lrck      (lrck),
        .l_din     (l_din),
        .r_din     (r_din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout      (dout),
        .underrun  (underrun)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic dout; logic ready; logic ur; } exp_t;
    exp_t          expq[$];
    exp_t          m_e, mon_e;
    logic          m_prev, m_full, m_hs, m_edge, m_ur;
    logic [WS-1:0] m_lbuf, m_rbuf, m_lw, m_rw, m_w;
    int            m_pos;   // bits already sent in the current slot; WS or more means padding

    always @(negedge bck) begin
        if (rst) begin
            m_prev = 1'b0; m_full = 1'b0; m_pos = WS;
            m_lbuf = '0; m_rbuf = '0; m_lw = '0; m_rw = '0;
            expq.delete();
        end else begin
            m_hs   = din_valid && !m_full;
            m_edge = (lrck != m_prev);
            m_prev = lrck;
            m_ur   = 1'b0;
            if (m_edge && !lrck) begin
                if (m_full) begin
                    m_lw = m_lbuf; m_rw = m_rbuf; m_full = 1'b0;
                end else begin
`ifndef I2S_TX_HOLD_LAST_EN
                    m_lw = '0; m_rw = '0;
`endif
                    m_ur = 1'b1;
                end
            end
            if (m_hs) begin
                m_lbuf = l_din; m_rbuf = r_din; m_full = 1'b1;
            end
            if (m_edge)        m_pos = 0;
            else if (m_pos < WS) m_pos++;
            m_w       = lrck ? m_rw : m_lw;
            m_e.dout  = (m_pos < WS) ? m_w[WS-1-m_pos] : 1'b0;
            m_e.ready = !m_full;
            m_e.ur    = m_ur;
            expq.push_back(m_e);
        end
    end

    // Monitor: outputs change on falling bck, so compare on the rising edge.
    always @(posedge bck) begin
        if (!rst && expq.size() > 0) begin
            mon_e = expq.pop_front();
            chk("dout", dout, mon_e.dout);
            chk("din_ready", din_ready, mon_e.ready);
            chk("underrun", underrun, mon_e.ur);
        end
    end

    // ---------------- stimulus ----------------
    int slot_len = 32;
    int slot_cnt = 0;

    // One bck period; returns whether a handshake happened on the falling edge just passed.
    task automatic tick(output bit hs);
        @(posedge bck);
        hs = din_valid && din_ready;
        @(negedge bck);
        #1;
        slot_cnt++;
        if (slot_cnt >= slot_len) begin
            slot_cnt = 0;
            lrck     = ~lrck;
        end
    endtask

    task automatic run(input int n);
        bit h;
        repeat (n) tick(h);
    endtask

    task automatic push(input logic [WS-1:0] l, input logic [WS-1:0] r, input int maxw);
        bit h;
        int w;
        w = 0;
        din_valid = 1'b1; l_din = l; r_din = r;
        do begin
            tick(h);
            w++;
        end while (!h && w < maxw);
        din_valid = 1'b0;
        checks++;
        if (!h) begin
            errors++;
            $display("FAIL push_timeout at t=%0t: got no handshake in %0d cycles, expected one", $time, maxw);
        end
    endtask

    task automatic wait_left_start();
        bit h;
        int n;
        n = 0;
        do begin
            tick(h);
            n++;
        end while (!(lrck == 1'b0 && slot_cnt == 0) && n < 1000);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("reset_dout", dout, 1'b0);
        chk("reset_din_ready", din_ready, 1'b1);
        chk("reset_underrun", underrun, 1'b0);
        repeat (3) @(negedge bck);
        #1 rst = 1'b0;

        // basic pair
        push(24'hA5A5A5, 24'h123456, 100);
        run(slot_len * 2 * 3);

        // empty buffer: underrun on the next left start
        run(slot_len * 2 * 2);

        // back-pressure: P2 waits for the left start that takes P1
        push(24'hC0FFEE, 24'h0BADF0, 100);
        push(24'h5A5A5A, 24'h3C3C3C, 300);
        run(slot_len * 2 * 3);

        // same-edge collision with an empty buffer
        run(slot_len * 2);
        wait_left_start();
        push(24'h13579B, 24'h2468AC, 5);
        run(slot_len * 2 * 2);

        // short slots truncate
        slot_len = 16;
        push(24'hFFFFFF, 24'($urandom), 100);
        run(16 * 2 * 4);

        // randomised traffic over varying slot lengths
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: slot_len = 16;
                1: slot_len = 24;
                2: slot_len = 25;
                3: slot_len = 32;
                default: slot_len = 40;
            endcase
            if ($urandom_range(0, 1) == 1) push(24'($urandom), 24'($urandom), 300);
            else run($urandom_range(1, 80));
        end
        run(200);

        // mid-word reset at bit 10 of a left word
        slot_len = 32;
        run(slot_len * 2 * 2);
        push(24'hFFFFFF, 24'hFFFFFF, 200);
        wait_left_start();
        run(14);
        @(posedge bck);
        #2 rst = 1'b1;
        #1;
        chk("midreset_dout", dout, 1'b0);
        chk("midreset_din_ready", din_ready, 1'b1);
        chk("midreset_underrun", underrun, 1'b0);
        run(2);
        rst = 1'b0;
        run(slot_len * 2);
        push(24'h800001, 24'h7FFFFE, 200);
        run(slot_len * 2 * 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

endmodule
